registered_mux_arbiter: RTL and testbench

REGISTERED_MUX_ARBITER -- requirements
Module: registered_mux_arbiter

---
 rtl/registered_mux_arbiter.sv | 127 ++++++++++++
 tb/tb_registered_mux_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/registered_mux_arbiter.sv
// Registered N-channel multiplexer with explicit-select or round-robin grant and a single-entry output register.
// Optional sticky out-of-range selector flag (Sel_Error) enabled by defining MUX_ARB_SEL_ERROR_EN.
module registered_mux_arbiter #(
  parameter int NBits     = 32,
  parameter int NChannels = 4,
  localparam int SelBits  = (NChannels > 1) ? $clog2(NChannels) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         Mode,
  input  logic [SelBits-1:0]           Selector,
  input  logic [NChannels-1:0]         In_Valid,
  input  logic [NChannels*NBits-1:0]   In_Data,
  output logic [NChannels-1:0]         In_Ready,
  output logic                         Out_Valid,
  input  logic                         Out_Ready,
  output logic [NBits-1:0]             Out_Data,
  output logic [SelBits-1:0]           Out_Channel
`ifdef MUX_ARB_SEL_ERROR_EN
  ,
  output logic                         Sel_Error
`endif
);

  logic               out_valid_q, out_valid_d;
  logic [NBits-1:0]   out_data_q,  out_data_d;
  logic [SelBits-1:0] out_chan_q,  out_chan_d;
  logic [SelBits-1:0] rr_ptr_q,    rr_ptr_d;

  logic               sel_in_range;
  logic               sel_valid;
  logic               rr_found;
  logic [SelBits-1:0] rr_idx;
  logic               grant_valid;
  logic [SelBits-1:0] grant_idx;
  logic [NBits-1:0]   grant_data;
  logic               load;

  // Explicit-select path: an out-of-range selector simply matches no channel.
  always_comb begin
    sel_in_range = (int'(Selector) < NChannels);
    sel_valid    = 1'b0;
    for (int i = 0; i < NChannels; i++) begin
      if (int'(Selector) == i) sel_valid = In_Valid[i];
    end
  end

  // Round-robin search: walk downward so the nearest channel after rr_ptr wins last.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int k = NChannels; k >= 1; k--) begin
      if (In_Valid[(int'(rr_ptr_q) + k) % NChannels]) begin
        rr_found = 1'b1;
        rr_idx   = SelBits'((int'(rr_ptr_q) + k) % NChannels);
      end
    end
  end

  always_comb begin
    grant_valid = Mode ? rr_found : sel_valid;
    grant_idx   = Mode ? rr_idx   : Selector;
    load        = !reset && (!out_valid_q || Out_Ready) && grant_valid;
  end

  always_comb begin
    grant_data = '0;
    In_Ready   = '0;
    for (int i = 0; i < NChannels; i++) begin
      if (int'(grant_idx) == i) begin
        grant_data  = In_Data[i*NBits +: NBits];
        In_Ready[i] = load;
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = grant_data;
      out_chan_d  = grant_idx;
      if (Mode) rr_ptr_d = grant_idx;
    end else if (Out_Ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      rr_ptr_q    <= SelBits'(NChannels - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign Out_Valid   = out_valid_q;
  assign Out_Data    = out_data_q;
  assign Out_Channel = out_chan_q;

`ifdef MUX_ARB_SEL_ERROR_EN
  logic sel_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_err_q <= 1'b0;
    end else if (!Mode && !sel_in_range) begin
      sel_err_q <= 1'b1;
    end
  end

  assign Sel_Error = sel_err_q;
`else
  logic unused_sel_range;
  assign unused_sel_range = sel_in_range;
`endif

endmodule

// File: tb/tb_registered_mux_arbiter.sv
// Bench for registered_mux_arbiter: a 4-channel and a 3-channel instance share stimulus and are
// checked every cycle against a queue-free behavioural model, plus directed literal scenarios.
module tb_registered_mux_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         mode;
  logic [1:0]   sel;
  logic [3:0]   in_valid;
  logic [127:0] in_data;
  logic         out_ready;

  logic [3:0]   a_in_ready;
  logic         a_out_valid;
  logic [31:0]  a_out_data;
  logic [1:0]   a_out_chan;
  logic [2:0]   b_in_ready;
  logic         b_out_valid;
  logic [31:0]  b_out_data;
  logic [1:0]   b_out_chan;
`ifdef MUX_ARB_SEL_ERROR_EN
  logic         a_sel_err;
  logic         b_sel_err;
`endif

  registered_mux_arbiter #(.NBits(32), .NChannels(4)) u_dut_a (
    .clk(clk), .reset(reset), .Mode(mode), .Selector(sel),
    .In_Valid(in_valid), .In_Data(in_data), .In_Ready(a_in_ready),
    .Out_Valid(a_out_valid), .Out_Ready(out_ready), .Out_Data(a_out_data),
    .Out_Channel(a_out_chan)
`ifdef MUX_ARB_SEL_ERROR_EN
    , .Sel_Error(a_sel_err)
`endif
  );

  registered_mux_arbiter #(.NBits(32), .NChannels(3)) u_dut_b (
    .clk(clk), .reset(reset), .Mode(mode), .Selector(sel),
    .In_Valid(in_valid[2:0]), .In_Data(in_data[95:0]), .In_Ready(b_in_ready),
    .Out_Valid(b_out_valid), .Out_Ready(out_ready), .Out_Data(b_out_data),
    .Out_Channel(b_out_chan)
`ifdef MUX_ARB_SEL_ERROR_EN
    , .Sel_Error(b_sel_err)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
    end
  endtask

  // Model state per instance: index 0 = 4 channels, index 1 = 3 channels.
  int          nch [2] = '{4, 3};
  bit          m_v [2] = '{0, 0};
  logic [31:0] m_d [2] = '{0, 0};
  int          m_c [2] = '{0, 0};
  int          m_rr[2] = '{3, 2};
  bit          m_err[2] = '{0, 0};

  function automatic void grant_of(input int n, input int rr, output bit ok, output int g);
    ok = 1'b0;
    g  = 0;
    if (!mode) begin
      if (int'(sel) < n && in_valid[int'(sel)]) begin
        ok = 1'b1;
        g  = int'(sel);
      end
    end else begin
      for (int k = 1; k <= n; k++) begin
        if (!ok && in_valid[(rr + k) % n]) begin
          ok = 1'b1;
          g  = (rr + k) % n;
        end
      end
    end
  endfunction

  function automatic logic [3:0] exp_ready(input int d);
    bit ok;
    int g;
    grant_of(nch[d], m_rr[d], ok, g);
    if (!reset && ok && (!m_v[d] || out_ready)) return 4'(1 << g);
    return 4'b0;
  endfunction

  always @(posedge clk) begin : model
    bit ok;
    int g;
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        m_v[d]   <= 1'b0;
        m_d[d]   <= '0;
        m_c[d]   <= 0;
        m_rr[d]  <= nch[d] - 1;
        m_err[d] <= 1'b0;
      end else begin
        grant_of(nch[d], m_rr[d], ok, g);
        if (ok && (!m_v[d] || out_ready)) begin
          m_v[d] <= 1'b1;
          m_d[d] <= in_data[g*32 +: 32];
          m_c[d] <= g;
          if (mode) m_rr[d] <= g;
        end else if (out_ready) begin
          m_v[d] <= 1'b0;
        end
        if (!mode && int'(sel) >= nch[d]) m_err[d] <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    chk("a.in_ready",  {28'b0, a_in_ready},        {28'b0, exp_ready(0)});
    chk("a.out_valid", {31'b0, a_out_valid},       {31'b0, m_v[0]});
    chk("a.out_data",  a_out_data,                 m_d[0]);
    chk("a.out_chan",  {30'b0, a_out_chan},        32'(m_c[0]));
    chk("b.in_ready",  {29'b0, b_in_ready},        {28'b0, exp_ready(1)});
    chk("b.out_valid", {31'b0, b_out_valid},       {31'b0, m_v[1]});
    chk("b.out_data",  b_out_data,                 m_d[1]);
    chk("b.out_chan",  {30'b0, b_out_chan},        32'(m_c[1]));
`ifdef MUX_ARB_SEL_ERROR_EN
    chk("a.sel_err",   {31'b0, a_sel_err},         {31'b0, m_err[0]});
    chk("b.sel_err",   {31'b0, b_sel_err},         {31'b0, m_err[1]});
`endif
  end

  int rr_seq[5] = '{0, 1, 2, 3, 0};

  initial begin
    reset     = 1'b1;
    mode      = 1'b0;
    sel       = 2'd0;
    in_valid  = 4'b0;
    in_data   = '0;
    out_ready = 1'b0;

    @(negedge clk);
    chk("rst.out_valid", {31'b0, a_out_valid}, 32'd0);
    chk("rst.out_data",  a_out_data,           32'd0);
    chk("rst.in_ready",  {28'b0, a_in_ready},  32'd0);

    // Explicit select of channel 2
    #1;
    reset = 1'b0; mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; out_ready = 1'b1;
    in_data[2*32 +: 32] = 32'hDEAD_BEEF;
    #1 chk("sel2.in_ready", {28'b0, a_in_ready}, 32'h4);
    @(negedge clk);
    chk("sel2.out_valid", {31'b0, a_out_valid}, 32'd1);
    chk("sel2.out_data",  a_out_data,           32'hDEAD_BEEF);
    chk("sel2.out_chan",  {30'b0, a_out_chan},  32'd2);

    // Round-robin, all requesting, no bubbles
    #1;
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = 32'h100 + 32'(i);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rr.out_valid", {31'b0, a_out_valid}, 32'd1);
      chk("rr.out_chan",  {30'b0, a_out_chan},  32'(rr_seq[i]));
    end

    // Stall: output and pointer frozen
    #1;
    out_ready = 1'b0; in_valid = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall.in_ready", {28'b0, a_in_ready}, 32'd0);
      chk("stall.out_chan", {30'b0, a_out_chan}, 32'd0);
      chk("stall.out_data", a_out_data,          32'h100);
    end
    #1 out_ready = 1'b1;
    #1 chk("unstall.in_ready", {28'b0, a_in_ready}, 32'h2);
    @(negedge clk);
    chk("unstall.out_chan", {30'b0, a_out_chan}, 32'd1);
    chk("unstall.out_data", a_out_data,          32'h101);

    // Drain with no grant: valid drops, data holds
    #1;
    mode = 1'b0; sel = 2'd1; in_valid = 4'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("drain.out_valid", {31'b0, a_out_valid}, 32'd0);
    chk("drain.out_data",  a_out_data,           32'h101);

    // Reset overrides a load in the same cycle
    #1;
    mode = 1'b1; in_valid = 4'b0010; in_data[1*32 +: 32] = 32'h1234; reset = 1'b1;
    #1 chk("rstload.in_ready", {28'b0, a_in_ready}, 32'd0);
    @(negedge clk);
    chk("rstload.out_valid", {31'b0, a_out_valid}, 32'd0);
    chk("rstload.out_data",  a_out_data,           32'd0);
    #1;
    reset = 1'b0; in_valid = 4'b1111;
    #1 chk("rstload.prio0", {28'b0, a_in_ready}, 32'h1);
    @(negedge clk);
    chk("rstload.out_chan", {30'b0, a_out_chan}, 32'd0);

    // Out-of-range selector on the 3-channel instance
    #1 reset = 1'b1;
    @(negedge clk);
    #1;
    reset = 1'b0; mode = 1'b0; sel = 2'd3; in_valid = 4'b0111; out_ready = 1'b1;
    #1 chk("oor.in_ready", {29'b0, b_in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("oor.out_valid", {31'b0, b_out_valid}, 32'd0);
`ifdef MUX_ARB_SEL_ERROR_EN
      chk("oor.sel_err", {31'b0, b_sel_err}, 32'd1);
`endif
    end
    #1 mode = 1'b1;
    @(negedge clk);
    chk("oor.rr_out_valid", {31'b0, b_out_valid}, 32'd1);
`ifdef MUX_ARB_SEL_ERROR_EN
    chk("oor.sticky", {31'b0, b_sel_err}, 32'd1);
`endif
    #1 reset = 1'b1;
    @(negedge clk);
`ifdef MUX_ARB_SEL_ERROR_EN
    chk("oor.cleared", {31'b0, b_sel_err}, 32'd0);
`endif
    #1 reset = 1'b0;

    // Randomized traffic, checked each cycle by the model
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      #1;
      reset     = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      sel       = 2'($urandom_range(0, 3));
      in_valid  = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = $urandom;
    end
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
